tag_lookup_ctrl_t0: RTL and testbench
=====================================

TAG_LOOKUP_CTRL_T0 -- requirements
Module: tag_lookup_ctrl_t0

Interface
REQ-001 SHALL have parameter AWIDTH, default 3, tag RAM index width; DEPTH = 1 << AWIDTH.
REQ-002 SHALL have parameter TWIDTH, default 13, tag field width; RAM word width DWIDTH = TWIDTH+1 (bit DWIDTH-1 = valid, bits TWIDTH-1:0 = tag).
REQ-003 SHALL use one clock and a synchronous, active-high reset:
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high reset
REQ-004 SHALL have these ports:
- req_valid  in  1  lookup request valid
- req_ready  out  1  controller can accept a request
- req_addr  in  TWIDTH+AWIDTH  {tag, index}; index = low AWIDTH bits
- req_alloc  in  1  on miss, write {1,tag} into the entry
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer takes result
- resp_hit  out  1  1 = hit, 0 = miss
- resp_index  out  AWIDTH  index of the completed lookup
- flush_start  in  1  one-cycle pulse: invalidate all entries
- flush_done  out  1  one-cycle pulse: flush complete
- ram_addr  out  AWIDTH  tag RAM address
- ram_din  out  DWIDTH  tag RAM write data
- ram_we  out  1  tag RAM write enable
- ram_dout  in  DWIDTH  tag RAM read data, valid the cycle after ram_addr is sampled

Function
REQ-005 SHALL implement states IDLE, LOOKUP, FILL, RESP, FLUSH.
REQ-006 SHALL assert req_ready only in IDLE, and only when flush_start is low.
REQ-007 In IDLE, ram_addr SHALL equal req_addr[AWIDTH-1:0] combinationally, so the RAM latches the index at the accept edge.
REQ-008 On an IDLE edge with req_valid & req_ready, SHALL register the tag, index and req_alloc, then go to LOOKUP.
REQ-009 In LOOKUP, ram_addr SHALL hold the registered index; hit = ram_dout[DWIDTH-1] & (ram_dout[TWIDTH-1:0] == registered tag).
REQ-010 At the LOOKUP edge, SHALL register resp_hit, then go to FILL if miss & alloc, else to RESP.
REQ-011 In FILL, SHALL assert ram_we for exactly one cycle with ram_addr = index and ram_din = {1'b1, tag}, then go to RESP.
REQ-012 In RESP, SHALL hold resp_valid=1 with stable resp_hit and resp_index until the edge with resp_ready=1, then return to IDLE.
REQ-013 Latency from accept edge to resp_valid high SHALL be 2 cycles (hit or no alloc) or 3 cycles (miss with alloc); a request is accepted at the earliest one cycle after resp handshake.
REQ-014 ram_we SHALL be 0 in IDLE, LOOKUP and RESP; a hit or a miss without alloc SHALL never write.
REQ-015 flush_start sampled high in IDLE SHALL take priority over a simultaneous req_valid and enter FLUSH; flush_start in any other state SHALL be ignored.
REQ-016 FLUSH SHALL write ram_din = 0 to indices 0..DEPTH-1 in order, one per cycle with ram_we=1 (DEPTH cycles), then pulse flush_done for one cycle in the first IDLE cycle.
REQ-017 The flush counter SHALL be AWIDTH+1 bits so that index DEPTH-1 is written before exit, with no wrap-around.
REQ-018 ram_din SHALL be 0 whenever ram_we=0.

Reset
REQ-019 While reset=1 at an edge: state=IDLE, resp_valid=0, resp_hit=0, resp_index=0, flush_done=0, flush counter=0, all request registers=0; ram_we SHALL be 0 in the cycle after reset.
REQ-020 Reset mid-FLUSH or mid-FILL SHALL abort immediately with no further writes; entries already written stay written, and no flush_done is issued.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- flush_start after reset -> ram_we high 8 consecutive cycles, addr 0..7, din 0; flush_done 1 cycle.
- Flushed RAM, req_addr={13'h0ABC,3'd5}, alloc=1 -> resp_hit=0, resp_index=5 at +3 cycles; entry 5 = 14'h2ABC.
- Same request repeated, alloc=0 -> resp_hit=1 at +2 cycles, no ram_we.
- Tag 13'h0ABD index 5, alloc=0 -> miss, entry 5 unchanged; resp_ready held low 4 cycles -> resp_valid/resp_hit stable, req_ready=0 throughout.
- flush_start and req_valid both high in IDLE -> FLUSH entered, request not accepted until flush_done.
- reset asserted on 3rd FLUSH cycle -> entries 0-1 cleared, 2-7 untouched, flush_done never pulses, req_ready=1 next cycle.

Source files
------------

// File: rtl/tag_lookup_ctrl_t0.sv
// Tag lookup controller: probes a synchronous tag RAM for {tag,index} hits,
// optionally allocates on miss, and sweeps the RAM clear on a flush request.
module tag_lookup_ctrl_t0 #(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned TWIDTH = 13
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [TWIDTH+AWIDTH-1:0] req_addr,
  input  logic                     req_alloc,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_hit,
  output logic [AWIDTH-1:0]        resp_index,
  input  logic                     flush_start,
  output logic                     flush_done,
  output logic [AWIDTH-1:0]        ram_addr,
  output logic [TWIDTH:0]          ram_din,
  output logic                     ram_we,
  input  logic [TWIDTH:0]          ram_dout
);

  localparam int unsigned DEPTH  = 1 << AWIDTH;
  localparam int unsigned DWIDTH = TWIDTH + 1;
  localparam int unsigned CWIDTH = AWIDTH + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FILL   = 3'd2,
    RESP   = 3'd3,
    FLUSH  = 3'd4
  } state_t;

  state_t              state;
  logic [TWIDTH-1:0]   tag_q;
  logic [AWIDTH-1:0]   idx_q;
  logic                alloc_q;
  logic [CWIDTH-1:0]   flush_cnt;
  logic [CWIDTH-1:0]   flush_cnt_nxt;
  logic                hit;

  assign hit           = ram_dout[DWIDTH-1] & (ram_dout[TWIDTH-1:0] == tag_q);
  assign flush_cnt_nxt = flush_cnt + CWIDTH'(1);

  // Flush wins over a same-cycle request, so it also blocks req_ready.
  assign req_ready = (state == IDLE) & ~flush_start;

  // RAM port; writes are gated by reset so an abort never lands a write.
  always_comb begin
    ram_addr = idx_q;
    ram_din  = '0;
    ram_we   = 1'b0;
    case (state)
      IDLE:  ram_addr = req_addr[AWIDTH-1:0];
      FILL: begin
        if (!reset) begin
          ram_we  = 1'b1;
          ram_din = {1'b1, tag_q};
        end
      end
      FLUSH: begin
        ram_addr = flush_cnt[AWIDTH-1:0];
        ram_we   = ~reset;
      end
      default: ;
    endcase
  end

  // Control FSM with registered response and flush-done outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tag_q      <= '0;
      idx_q      <= '0;
      alloc_q    <= 1'b0;
      flush_cnt  <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_index <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_start) begin
            flush_cnt <= '0;
            state     <= FLUSH;
          end else if (req_valid) begin
            tag_q   <= req_addr[AWIDTH +: TWIDTH];
            idx_q   <= req_addr[AWIDTH-1:0];
            alloc_q <= req_alloc;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          resp_hit   <= hit;
          resp_index <= idx_q;
          if (!hit && alloc_q) begin
            state <= FILL;
          end else begin
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        FILL: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        FLUSH: begin
          // Counter is one bit wider than the index so DEPTH is reachable.
          flush_cnt <= flush_cnt_nxt;
          if (flush_cnt_nxt == CWIDTH'(DEPTH)) begin
            flush_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_lookup_ctrl_t0.sv
// Directed bench for tag_lookup_ctrl_t0 with a behavioural synchronous tag RAM.
module tb_tag_lookup_ctrl_t0;

  localparam int unsigned AWIDTH = 3;
  localparam int unsigned TWIDTH = 13;
  localparam int unsigned DWIDTH = TWIDTH + 1;
  localparam int unsigned DEPTH  = 1 << AWIDTH;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     req_valid;
  logic                     req_ready;
  logic [TWIDTH+AWIDTH-1:0] req_addr;
  logic                     req_alloc;
  logic                     resp_valid;
  logic                     resp_ready;
  logic                     resp_hit;
  logic [AWIDTH-1:0]        resp_index;
  logic                     flush_start;
  logic                     flush_done;
  logic [AWIDTH-1:0]        ram_addr;
  logic [DWIDTH-1:0]        ram_din;
  logic                     ram_we;
  logic [DWIDTH-1:0]        ram_dout;

  logic [DWIDTH-1:0] mem [DEPTH];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [TWIDTH-1:0] tag;
    logic [AWIDTH-1:0] idx;
    logic              alloc;
    logic              exp_hit;
    int                exp_lat;
    int                hold;
  } vec_t;

  vec_t vecs[$];

  tag_lookup_ctrl_t0 #(.AWIDTH(AWIDTH), .TWIDTH(TWIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_alloc  (req_alloc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_hit   (resp_hit),
    .resp_index (resp_index),
    .flush_start(flush_start),
    .flush_done (flush_done),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout)
  );

  always #5 clock = ~clock;

  // Synchronous single-port RAM, read-before-write.
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write data must be zero whenever no write is happening.
  always @(negedge clock) begin
    if (reset === 1'b0 && ram_we === 1'b0) chk("din_idle_zero", 32'(ram_din), 32'd0);
  end

  // Continues a request from just after its accept edge through the handshake.
  task automatic finish_req(input vec_t v);
    int lat;
    int wes;
    @(negedge clock);
    req_valid = 1'b0;
    req_alloc = 1'b0;
    lat = 1;
    wes = 0;
    while (!resp_valid && lat < 10) begin
      if (ram_we) begin
        wes++;
        chk("fill_addr", 32'(ram_addr), 32'(v.idx));
        chk("fill_din", 32'(ram_din), 32'({1'b1, v.tag}));
      end
      @(negedge clock);
      lat++;
    end
    chk("resp_valid_seen", 32'(resp_valid), 32'd1);
    chk("latency", 32'(lat), 32'(v.exp_lat));
    chk("resp_hit", 32'(resp_hit), 32'(v.exp_hit));
    chk("resp_index", 32'(resp_index), 32'(v.idx));
    chk("write_count", 32'(wes), (v.alloc && !v.exp_hit) ? 32'd1 : 32'd0);
    chk("resp_no_we", 32'(ram_we), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clock);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_hit", 32'(resp_hit), 32'(v.exp_hit));
      chk("hold_index", 32'(resp_index), 32'(v.idx));
    end
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    #1;
    chk("post_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic do_req(input vec_t v);
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = {v.tag, v.idx};
    req_alloc = v.alloc;
    #1;
    chk("accept_ready", 32'(req_ready), 32'd1);
    chk("idle_ram_addr", 32'(ram_addr), 32'(v.idx));
    @(posedge clock);
    finish_req(v);
  endtask

  task automatic do_flush(input bit with_req);
    vec_t v;
    v = '{13'h0AAA, 3'd2, 1'b1, 1'b0, 3, 0};
    @(negedge clock);
    flush_start = 1'b1;
    if (with_req) begin
      req_valid = 1'b1;
      req_addr  = {v.tag, v.idx};
      req_alloc = v.alloc;
    end
    #1;
    chk("flush_blocks_ready", 32'(req_ready), 32'd0);
    @(posedge clock);
    @(negedge clock);
    flush_start = 1'b0;
    #1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      chk("flush_we", 32'(ram_we), 32'd1);
      chk("flush_addr", 32'(ram_addr), 32'(i));
      chk("flush_din", 32'(ram_din), 32'd0);
      chk("flush_req_ready", 32'(req_ready), 32'd0);
      chk("flush_done_early", 32'(flush_done), 32'd0);
      @(negedge clock);
    end
    chk("flush_end_we", 32'(ram_we), 32'd0);
    chk("flush_done_pulse", 32'(flush_done), 32'd1);
    if (with_req) begin
      chk("ready_at_done", 32'(req_ready), 32'd1);
      @(posedge clock);
      finish_req(v);
    end else begin
      @(negedge clock);
      chk("flush_done_one_cycle", 32'(flush_done), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_alloc = 1'b0;
    resp_ready = 1'b0; flush_start = 1'b0;

    vecs.push_back('{13'h0ABC, 3'd5, 1'b1, 1'b0, 3, 0});
    vecs.push_back('{13'h0ABC, 3'd5, 1'b0, 1'b1, 2, 0});
    vecs.push_back('{13'h0ABD, 3'd5, 1'b0, 1'b0, 2, 4});
    vecs.push_back('{13'h0000, 3'd0, 1'b0, 1'b0, 2, 0});
    for (int i = 0; i < int'(DEPTH); i++)
      vecs.push_back('{13'h0100 + 13'(i), 3'(i), 1'b1, 1'b0, 3, 0});
    for (int i = 0; i < int'(DEPTH); i++)
      vecs.push_back('{13'h0100 + 13'(i), 3'(i), 1'b0, 1'b1, 2, 0});
    vecs.push_back('{13'h1FFF, 3'd7, 1'b0, 1'b0, 2, 0});
    vecs.push_back('{13'h0103, 3'd3, 1'b1, 1'b1, 2, 1});

    repeat (2) @(negedge clock);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    chk("rst_resp_index", 32'(resp_index), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_we_after", 32'(ram_we), 32'd0);

    do_flush(1'b0);
    for (int i = 0; i < int'(DEPTH); i++) chk("mem_flushed", 32'(mem[i]), 32'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      do_req(vecs[k]);
      if (k == 0 || k == 2) chk("entry5", 32'(mem[5]), 32'h2ABC);
    end
    for (int i = 0; i < int'(DEPTH); i++)
      chk("mem_filled", 32'(mem[i]), 32'(14'h2100 + 14'(i)));

    do_flush(1'b1);
    for (int i = 0; i < int'(DEPTH); i++)
      chk("mem_after_collision", 32'(mem[i]), (i == 2) ? 32'h2AAA : 32'd0);

    for (int i = 0; i < int'(DEPTH); i++)
      do_req('{13'h0100 + 13'(i), 3'(i), 1'b1, 1'b0, 3, 0});

    // Reset during the third flush cycle must stop the sweep at index 2.
    @(negedge clock);
    flush_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    flush_start = 1'b0;
    #1;
    chk("abort_addr0", 32'(ram_addr), 32'd0);
    @(negedge clock);
    chk("abort_addr1", 32'(ram_addr), 32'd1);
    @(negedge clock);
    chk("abort_addr2", 32'(ram_addr), 32'd2);
    reset = 1'b1;
    #1;
    chk("abort_we_gated", 32'(ram_we), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 10; c++) begin
      chk("abort_no_done", 32'(flush_done), 32'd0);
      chk("abort_no_we", 32'(ram_we), 32'd0);
      @(negedge clock);
    end
    for (int i = 0; i < int'(DEPTH); i++)
      chk("mem_after_abort", 32'(mem[i]), (i < 2) ? 32'd0 : 32'(14'h2100 + 14'(i)));
    do_req('{13'h0102, 3'd2, 1'b0, 1'b1, 2, 0});
    do_req('{13'h0101, 3'd1, 1'b0, 1'b0, 2, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
